// File: rtl/status_array_if.sv
// Request/response bundle between a requester (initializer or cache pipeline) and status_array.
// master = requester side, slave = array side.
interface status_array_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_BLOCKS = 4,
  parameter int ROW_WIDTH  = 8
);
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [ROW_WIDTH-1:0]  i_data;
  logic                  i_wen;
  logic [NUM_BLOCKS-1:0] i_wmask;
  logic                  i_valid;
  logic                  o_ready;
  logic [ROW_WIDTH-1:0]  o_rdata;
  logic                  o_rdata_valid;
  logic                  o_wack;
  logic                  o_uninit_read;

  modport master (
    output i_addr, i_data, i_wen, i_wmask, i_valid,
    input  o_ready, o_rdata, o_rdata_valid, o_wack, o_uninit_read
  );

  modport slave (
    input  i_addr, i_data, i_wen, i_wmask, i_valid,
    output o_ready, o_rdata, o_rdata_valid, o_wack, o_uninit_read
  );
endinterface

// File: rtl/status_array.sv
// Register-based instruction-cache status array: masked writes and registered reads via one request port.
// Optional macro STATUS_ARRAY_INIT_CHECK_EN adds never-written-row detection on o_uninit_read.
module status_array #(
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_BLOCKS = 4,
  parameter int ROW_WIDTH  = 8
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          i_halt,
  status_array_if.slave bus
);
  localparam int BW    = ROW_WIDTH / NUM_BLOCKS;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  function automatic logic [ROW_WIDTH-1:0] expand_mask(input logic [NUM_BLOCKS-1:0] m);
    logic [ROW_WIDTH-1:0] x;
    x = '0;
    for (int b = 0; b < NUM_BLOCKS; b++) begin
      x[b*BW +: BW] = {BW{m[b]}};
    end
    return x;
  endfunction

  logic [ROW_WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ROW_WIDTH-1:0]  r_data;
  logic                  r_wen;
  logic [NUM_BLOCKS-1:0] r_wmask;
  logic                  r_valid;
  logic [ROW_WIDTH-1:0]  r_rdata;
  logic                  r_rdata_valid;
  logic                  r_wack;

  logic                  w_run;
  logic                  w_accept;
  logic                  w_do_write;
  logic                  w_do_read;
  logic [ROW_WIDTH-1:0]  w_bitmask;

  // i_halt acts as the clock gate: with it high no state element may change.
  assign w_run      = ~i_halt;
  assign w_accept   = bus.i_valid & w_run;
  assign w_do_write = r_valid & r_wen;
  assign w_do_read  = r_valid & ~r_wen;
  assign w_bitmask  = expand_mask(r_wmask);

  assign bus.o_ready       = w_run;
  assign bus.o_rdata       = r_rdata;
  assign bus.o_rdata_valid = r_rdata_valid;
  assign bus.o_wack        = r_wack;

  // Request stage capture
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_wen   <= 1'b0;
      r_wmask <= '0;
    end else if (w_run) begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_addr  <= bus.i_addr;
        r_data  <= bus.i_data;
        r_wen   <= bus.i_wen;
        r_wmask <= bus.i_wmask;
      end
    end
  end

  // Array update; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (w_run && w_do_write) begin
      r_mem[r_addr] <= (r_mem[r_addr] & ~w_bitmask) | (r_data & w_bitmask);
    end
  end

  // Completion outputs: read data capture and one-cycle valid/ack pulses
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_wack        <= 1'b0;
    end else if (w_run) begin
      r_rdata_valid <= w_do_read;
      r_wack        <= w_do_write;
      if (w_do_read) begin
        r_rdata <= r_mem[r_addr];
      end
    end
  end

`ifdef STATUS_ARRAY_INIT_CHECK_EN
  logic [DEPTH-1:0] r_written;
  logic             r_uninit_read;

  assign bus.o_uninit_read = r_uninit_read;

  // Written-row tracking; a zero-mask write still marks the row
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_written     <= '0;
      r_uninit_read <= 1'b0;
    end else if (w_run) begin
      r_uninit_read <= w_do_read & ~r_written[r_addr];
      if (w_do_write) begin
        r_written[r_addr] <= 1'b1;
      end
    end
  end
`else
  assign bus.o_uninit_read = 1'b0;
`endif
endmodule
